reg_write_arbiter: RTL and testbench

Sequencing and sharing controller for the CPU's bank of level-sensitive `register` instances. It arbitrates write requests from two requesters, such as ALU writeback and memory load, using a valid/ready handshake. Each accepted request becomes a registered one-hot write-enable pulse and a held data bus that drive the register bank. It also generates the bank's clear signal after reset.

---
 rtl/reg_write_arbiter.sv | 136 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Arbitrates write requests from two requesters onto a bank of
//   level-sensitive registers. Each accepted request becomes a one-cycle
//   one-hot write-enable pulse plus a data bus that is held until the next
//   accepted request. After reset the block also drives the bank clear.
//
//   Optional feature macro: REGWR_ARB_RR_EN
//     defined   -> round-robin arbitration between the two requesters
//     undefined -> fixed priority, requester 0 wins ties
//
// Ports
//   clk                    system clock, rising edge
//   reset                  synchronous, active-low
//   req0_valid/addr/data   requester 0 write request
//   req0_ready             requester 0 accepted this cycle
//   req1_valid/addr/data   requester 1 write request
//   req1_ready             requester 1 accepted this cycle
//   we_out     [NREG]      one-hot register write enables
//   wdata_out  [SIZE]      shared write data bus
//   clear_out              bank clear, high in reset and the CLEAR state
//   err_out                sticky: an out-of-range address was accepted
//   busy                   high in CLEAR and WRITE
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | bank clear asserted, no requests accepted
// ST_IDLE  | readies follow arbitration, transfer moves to ST_WRITE
// ST_WRITE | one-hot write enable held for one cycle, readies low

module reg_write_arbiter #(
  parameter int SIZE   = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [SIZE-1:0]   req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [SIZE-1:0]   req1_data,
  output logic              req1_ready,
  output logic [NREG-1:0]   we_out,
  output logic [SIZE-1:0]   wdata_out,
  output logic              clear_out,
  output logic              err_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic              sel1;
  logic [ADDR_W-1:0] sel_addr;
  logic [SIZE-1:0]   sel_data;
  logic [NREG-1:0]   we_next;
  logic              oob;

`ifdef REGWR_ARB_RR_EN
  // last holds the most recent grant; on a tie the other requester wins.
  logic last;
  assign grant0 = req0_valid && (!req1_valid || last);
`else
  assign grant0 = req0_valid;
`endif
  assign grant1 = req1_valid && !grant0;

  // Readies are gated by reset so nothing is accepted at the reset edge.
  assign req0_ready = reset && (state == ST_IDLE) && grant0;
  assign req1_ready = reset && (state == ST_IDLE) && grant1;

  assign xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel1     = req1_ready;
  assign sel_addr = sel1 ? req1_addr : req0_addr;
  assign sel_data = sel1 ? req1_data : req0_data;
  assign oob      = int'(sel_addr) >= NREG;

  // Out-of-range addresses match no index and decode to all zeros.
  always_comb begin
    we_next = '0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(sel_addr) == i) we_next[i] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: state_next = ST_IDLE;
      ST_IDLE:  if (xfer) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      we_out    <= '0;
      wdata_out <= '0;
      err_out   <= 1'b0;
`ifdef REGWR_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      state <= state_next;
      // Enable is a single-cycle pulse; data is only touched on transfer
      // so it stays stable across the edge where the enable falls.
      we_out <= xfer ? we_next : '0;
      if (xfer) begin
        wdata_out <= sel_data;
        if (oob) err_out <= 1'b1;
`ifdef REGWR_ARB_RR_EN
        last <= sel1;
`endif
      end
    end
  end

  // Reset is folded in combinationally so clear/busy are high for the
  // whole time reset is low, not just from the first sampled edge.
  assign clear_out = !reset || (state == ST_CLEAR);
  assign busy      = !reset || (state != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int SIZE   = 16;
  localparam int NREG   = 6;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [SIZE-1:0]   req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic [NREG-1:0]   we_out;
  logic [SIZE-1:0]   wdata_out;
  logic              clear_out, err_out, busy;

  logic [SIZE-1:0]   bank [NREG];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.SIZE(SIZE), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .we_out     (we_out),
    .wdata_out  (wdata_out),
    .clear_out  (clear_out),
    .err_out    (err_out),
    .busy       (busy)
  );

  // Level-sensitive register bank model, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (clear_out) bank[i] = '0;
      else if (we_out[i]) bank[i] = wdata_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it through WRITE; called at posedge+1.
  task automatic do_write(input int req, input logic [ADDR_W-1:0] addr,
                          input logic [SIZE-1:0] data, input logic [NREG-1:0] exp_we);
    bit got_it = 0;
    if (req == 0) begin req0_valid = 1; req0_addr = addr; req0_data = data; end
    else          begin req1_valid = 1; req1_addr = addr; req1_data = data; end
    for (int c = 0; c < 10 && !got_it; c++) begin
      @(negedge clk);
      if ((req == 0) ? req0_ready : req1_ready) got_it = 1;
      next_cycle();
    end
    chk("write_granted", 32'(got_it), 32'd1);
    req0_valid = 0;
    req1_valid = 0;
    @(negedge clk);
    chk("write_we_pulse", 32'(we_out), 32'(exp_we));
    chk("write_data", 32'(wdata_out), 32'(data));
    chk("write_busy", 32'(busy), 32'd1);
    chk("write_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("write_we_fall", 32'(we_out), 32'd0);
    chk("write_data_held", 32'(wdata_out), 32'(data));
    next_cycle();
  endtask

  logic [1:0]      exp_rdy [5];
  logic [NREG-1:0] exp_we  [5];

  initial begin
    reset = 0;
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;

    // Reset held for 3 cycles, then one CLEAR cycle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_clear", 32'(clear_out), 32'd1);
      chk("rst_we", 32'(we_out), 32'd0);
      chk("rst_wdata", 32'(wdata_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
    end
    next_cycle();
    reset = 1;
    req0_valid = 1; req0_addr = 3'd1; req0_data = 16'h1111;
    req1_valid = 1; req1_addr = 3'd2; req1_data = 16'h2222;
    @(negedge clk);
    chk("clear_cycle", 32'(clear_out), 32'd1);
    chk("clear_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("clear_err", 32'(err_out), 32'd0);
    next_cycle();

    // Tie with both requesters continuously valid.
`ifdef REGWR_ARB_RR_EN
    exp_rdy = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    exp_we  = '{6'b000000, 6'b000010, 6'b000000, 6'b000100, 6'b000000};
`else
    exp_rdy = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    exp_we  = '{6'b000000, 6'b000010, 6'b000000, 6'b000010, 6'b000000};
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("tie_clear_off", 32'(clear_out), 32'd0);
      chk($sformatf("tie_ready_%0d", c), 32'({req0_ready, req1_ready}), 32'(exp_rdy[c]));
      chk($sformatf("tie_we_%0d", c), 32'(we_out), 32'(exp_we[c]));
      next_cycle();
    end
    req0_valid = 0;
    @(negedge clk);
    chk("tie_last_we", 32'(we_out), 32'b000010);
    next_cycle();
    @(negedge clk);
    chk("tie_req1_pending", 32'({req0_ready, req1_ready}), 32'b01);
    next_cycle();
    req1_valid = 0;
    @(negedge clk);
    chk("tie_req1_we", 32'(we_out), 32'b000100);
    chk("tie_req1_data", 32'(wdata_out), 32'h2222);
    next_cycle();
    @(negedge clk);
    chk("tie_bank1", 32'(bank[1]), 32'h1111);
    chk("tie_bank2", 32'(bank[2]), 32'h2222);
    next_cycle();

    // Single write.
    do_write(0, 3'd3, 16'hBEEF, 6'b001000);
    @(negedge clk);
    chk("bank3", 32'(bank[3]), 32'hBEEF);
    chk("err_before_oob", 32'(err_out), 32'd0);
    next_cycle();

    // Out-of-range address on requester 1.
    do_write(1, 3'd7, 16'h7777, 6'b000000);
    @(negedge clk);
    chk("oob_err", 32'(err_out), 32'd1);
    chk("oob_bank3", 32'(bank[3]), 32'hBEEF);
    next_cycle();

    // Back-to-back writes to register 0.
    do_write(0, 3'd0, 16'hAAAA, 6'b000001);
    do_write(0, 3'd0, 16'h5555, 6'b000001);
    @(negedge clk);
    chk("bank0_final", 32'(bank[0]), 32'h5555);
    chk("err_sticky", 32'(err_out), 32'd1);
    next_cycle();

    // Reset during WRITE.
    req1_valid = 1; req1_addr = 3'd5; req1_data = 16'h1234;
    @(negedge clk);
    chk("mid_ready", 32'(req1_ready), 32'd1);
    next_cycle();
    req1_valid = 0;
    reset = 0;
    @(negedge clk);
    chk("mid_write_we", 32'(we_out), 32'b100000);
    next_cycle();
    @(negedge clk);
    chk("mid_we_cleared", 32'(we_out), 32'd0);
    chk("mid_clear", 32'(clear_out), 32'd1);
    chk("mid_err_cleared", 32'(err_out), 32'd0);
    next_cycle();
    reset = 1;
    @(negedge clk);
    chk("mid_clear_cycle", 32'(clear_out), 32'd1);
    for (int i = 0; i < NREG; i++)
      chk($sformatf("mid_bank%0d", i), 32'(bank[i]), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("mid_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
